crypto1_stream_ctrl: RTL and testbench
======================================

# crypto1_stream_ctrl

Sequencer that owns the Crypto1 keystream core and turns it into a byte-wide encryption engine. It loads the 48-bit key, primes the core's registered output, then consumes plaintext bytes on a valid/ready input. Each byte is XORed LSB-first with 8 keystream bits, and the engine emits the ciphertext byte plus an encrypted odd-parity bit on a valid/ready output. It sits between the frame/link logic and the Crypto1 instance, and is the only driver of the core's INIT/STB.

## Interface
- PARITY_EN, 1, 1 = generate encrypted parity (PAR state); 0 = skip PAR, OUT_PAR held 0
- CLK  in  1  clock
- RESETn  in  1  synchronous, active-low reset
- KEY_IN  in  48  key, sampled on KEY_LOAD
- KEY_LOAD  in  1  single-cycle load request; highest priority in every state
- KEYED  out  1  core initialised and primed
- BUSY  out  1  high in LOAD, PRIME, SHIFT, PAR
- IN_VALID  in  1  plaintext byte valid
- IN_READY  out  1  high only in READY
- IN_DATA  in  8  plaintext byte, bit0 processed first
- OUT_VALID  out  1  ciphertext valid; held until OUT_READY
- OUT_READY  in  1  sink accepts
- OUT_DATA  out  8  ciphertext byte
- OUT_PAR  out  1  encrypted parity
- BYTE_CNT  out  16  bytes delivered since last key load, saturates at 0xFFFF
- C1_KEY  out  48  key to core (registered copy of KEY_IN)
- C1_INIT  out  1  core load strobe
- C1_STB  out  1  core advance strobe
- C1_OUT  in  1  core keystream bit (registered in core, updated the cycle after C1_STB)

## Operation
- States: UNKEYED, LOAD, PRIME, READY, SHIFT, PAR, OUT.
- Reset: state UNKEYED; every output 0, including C1_KEY, OUT_DATA and BYTE_CNT.
- KEY_LOAD in any state:
  - latch KEY_IN into C1_KEY and go to LOAD;
  - discard any in-flight byte or pending output, with OUT_VALID dropping next cycle;
  - clear BYTE_CNT and KEYED.
- LOAD: C1_INIT=1 for one cycle, then PRIME.
- PRIME: C1_STB=1 for one cycle. C1_OUT is valid from the next cycle. Go to READY and set KEYED=1.
- READY: IN_READY=1. On IN_VALID&IN_READY, latch IN_DATA into the plaintext and shift registers, clear bit index k, and go to SHIFT.
- SHIFT, k=0..7, one cycle each:
  - cipher[k] = plain[k] ^ C1_OUT;
  - C1_STB=1 every cycle;
  - after k=7, go to PAR if PARITY_EN=1, otherwise OUT.
- PAR: one cycle, C1_STB=0.
  - C1_OUT now holds the keystream bit that will also encrypt bit0 of the next byte; the keystream is deliberately not advanced.
  - parity = ~^plain (odd parity) ^ C1_OUT.
- OUT: OUT_VALID=1 with OUT_DATA/OUT_PAR stable. On OUT_READY, increment BYTE_CNT (saturating) and go to READY.
- KEY_LOAD has priority over a same-cycle input or output handshake. Neither handshake completes, and BYTE_CNT does not increment.
- IN_VALID while UNKEYED/LOAD/PRIME is ignored (IN_READY=0).
- C1_INIT and C1_STB are never high in the same cycle.

## Timing
- Key load, KEY_LOAD at cycle t:
  - C1_INIT at t+1;
  - C1_STB at t+2;
  - KEYED=1 and IN_READY=1 at t+3.
- Byte path, input handshake at cycle t:
  - SHIFT t+1..t+8, with C1_STB=1 in exactly those 8 cycles;
  - PAR t+9;
  - OUT_VALID=1 at t+10 (PARITY_EN=0: t+9).
- OUT_READY at cycle u: OUT_VALID=0 and IN_READY=1 at u+1, and BYTE_CNT is updated at u+1.
- Maximum throughput is one byte per 11 cycles (10 cycles with PARITY_EN=0), with OUT_READY tied high and IN_VALID continuous.
- Strobe count is exactly 1 (PRIME) + 8 per delivered byte.
- An aborted byte leaves the core advanced by however many SHIFT cycles completed. This is harmless because KEY_LOAD re-initialises the core.

## Test plan
- Reset, then idle: all outputs 0, state UNKEYED. IN_VALID=1 with 0x3C is never accepted (IN_READY stays 0).
- Key load sequencing: KEY_LOAD with 0xA0A1A2A3A4A5 -> C1_KEY=0xA0A1A2A3A4A5; C1_INIT at t+1, C1_STB at t+2, KEYED at t+3; no other strobes.
- Stub core C1_OUT=1:
  - IN_DATA 0xA5 -> OUT_DATA 0x5A, OUT_PAR 0;
  - IN_DATA 0x01 -> OUT_DATA 0xFE, OUT_PAR 1;
  - OUT_VALID exactly 10 cycles after the input handshake.
- Stub core with C1_OUT toggling after each C1_STB (starting at 0):
  - 0x00 -> 0xAA;
  - the PAR cycle sees the next bit without a strobe;
  - the following byte's bit0 uses that same bit.
- Backpressure: hold OUT_READY=0 for 20 cycles -> OUT_VALID and OUT_DATA stable, IN_READY=0, no C1_STB; release -> BYTE_CNT +1.
- Abort: KEY_LOAD during SHIFT k=4 and again coincident with an OUT handshake -> output dropped, BYTE_CNT=0, full LOAD/PRIME sequence. Also cover PARITY_EN=0 latency of 9 cycles and BYTE_CNT saturation at 0xFFFF.

Source files
------------

// File: rtl/crypto1_stream_ctrl.sv
// Byte-wide stream cipher sequencer around a Crypto1 keystream core.
// Loads and primes the core, then XORs plaintext bytes LSB-first and appends encrypted odd parity.
module crypto1_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             PARITY_EN,
  input  logic [47:0]      KEY_IN,
  input  logic             KEY_LOAD,
  output logic             KEYED,
  output logic             BUSY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       OUT_DATA,
  output logic             OUT_PAR,
  output logic [CNT_W-1:0] BYTE_CNT,
  output logic [47:0]      C1_KEY,
  output logic             C1_INIT,
  output logic             C1_STB,
  input  logic             C1_OUT
);

  typedef enum logic [2:0] {
    UNKEYED,
    LOAD,
    PRIME,
    READY,
    SHIFT,
    PAR,
    OUT
  } state_t;

  state_t           state_reg;
  logic             keyed_reg;
  logic             busy_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [7:0]       out_data_reg;
  logic             out_par_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [47:0]      key_reg;
  logic             init_reg;
  logic             stb_reg;
  logic [7:0]       plain_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       cipher_reg;
  logic [2:0]       bit_idx_reg;

  logic             cipher_bit;
  logic [7:0]       cipher_next;
  logic             parity_next;

  // Cipher bits enter at the MSB so that after 8 shifts bit0 holds the first keystream bit.
  assign cipher_bit  = shift_reg[0] ^ C1_OUT;
  assign cipher_next = {cipher_bit, cipher_reg[7:1]};
  assign parity_next = (~^plain_reg) ^ C1_OUT;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_reg     <= UNKEYED;
      keyed_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      out_par_reg   <= 1'b0;
      byte_cnt_reg  <= '0;
      key_reg       <= 48'h0;
      init_reg      <= 1'b0;
      stb_reg       <= 1'b0;
      plain_reg     <= 8'h00;
      shift_reg     <= 8'h00;
      cipher_reg    <= 8'h00;
      bit_idx_reg   <= 3'd0;
    end else if (KEY_LOAD) begin
      // A key load wins over any handshake and abandons work in flight.
      state_reg     <= LOAD;
      key_reg       <= KEY_IN;
      init_reg      <= 1'b1;
      stb_reg       <= 1'b0;
      keyed_reg     <= 1'b0;
      busy_reg      <= 1'b1;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      byte_cnt_reg  <= '0;
    end else begin
      init_reg <= 1'b0;
      stb_reg  <= 1'b0;
      case (state_reg)
        UNKEYED: begin
          busy_reg <= 1'b0;
        end
        LOAD: begin
          state_reg <= PRIME;
          stb_reg   <= 1'b1;
          busy_reg  <= 1'b1;
        end
        PRIME: begin
          state_reg    <= READY;
          keyed_reg    <= 1'b1;
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
        end
        READY: begin
          if (IN_VALID) begin
            plain_reg    <= IN_DATA;
            shift_reg    <= IN_DATA;
            bit_idx_reg  <= 3'd0;
            state_reg    <= SHIFT;
            stb_reg      <= 1'b1;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
          end
        end
        SHIFT: begin
          cipher_reg  <= cipher_next;
          shift_reg   <= {1'b0, shift_reg[7:1]};
          bit_idx_reg <= bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            if (PARITY_EN) begin
              state_reg <= PAR;
            end else begin
              state_reg     <= OUT;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b1;
              out_data_reg  <= cipher_next;
              out_par_reg   <= 1'b0;
            end
          end else begin
            stb_reg <= 1'b1;
          end
        end
        PAR: begin
          // No strobe here: the bit used for parity also encrypts bit0 of the next byte.
          state_reg     <= OUT;
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b1;
          out_data_reg  <= cipher_reg;
          out_par_reg   <= parity_next;
        end
        OUT: begin
          if (OUT_READY) begin
            state_reg     <= READY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            if (byte_cnt_reg != '1) begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end
        end
        default: begin
          state_reg <= UNKEYED;
        end
      endcase
    end
  end

  assign KEYED     = keyed_reg;
  assign BUSY      = busy_reg;
  assign IN_READY  = in_ready_reg;
  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = out_data_reg;
  assign OUT_PAR   = out_par_reg;
  assign BYTE_CNT  = byte_cnt_reg;
  assign C1_KEY    = key_reg;
  assign C1_INIT   = init_reg;
  assign C1_STB    = stb_reg;

endmodule

// File: tb/tb_crypto1_stream_ctrl.sv
// Directed bench for crypto1_stream_ctrl with a stub keystream core (constant-1 or toggling).
// A second instance with a 4-bit byte counter shares all stimulus to reach saturation quickly.
module tb_crypto1_stream_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        PARITY_EN = 1'b1;
  logic [47:0] KEY_IN = 48'h0;
  logic        KEY_LOAD = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        OUT_READY = 1'b0;
  logic        C1_OUT;

  logic        KEYED, BUSY, IN_READY, OUT_VALID, OUT_PAR, C1_INIT, C1_STB;
  logic [7:0]  OUT_DATA;
  logic [15:0] BYTE_CNT;
  logic [47:0] C1_KEY;

  logic        s_keyed, s_busy, s_in_ready, s_out_valid, s_out_par, s_init, s_stb;
  logic [7:0]  s_out_data;
  logic [3:0]  s_byte_cnt;
  logic [47:0] s_key;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int init_cnt = 0;
  int overlap_cnt = 0;
  logic tog = 1'b0;
  logic tog_mode = 1'b0;

  always #5 CLK = ~CLK;

  crypto1_stream_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .PARITY_EN(PARITY_EN), .KEY_IN(KEY_IN), .KEY_LOAD(KEY_LOAD),
    .KEYED(KEYED), .BUSY(BUSY), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_PAR(OUT_PAR),
    .BYTE_CNT(BYTE_CNT), .C1_KEY(C1_KEY), .C1_INIT(C1_INIT), .C1_STB(C1_STB), .C1_OUT(C1_OUT)
  );

  crypto1_stream_ctrl #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RESETn(RESETn), .PARITY_EN(PARITY_EN), .KEY_IN(KEY_IN), .KEY_LOAD(KEY_LOAD),
    .KEYED(s_keyed), .BUSY(s_busy), .IN_VALID(IN_VALID), .IN_READY(s_in_ready), .IN_DATA(IN_DATA),
    .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY), .OUT_DATA(s_out_data), .OUT_PAR(s_out_par),
    .BYTE_CNT(s_byte_cnt), .C1_KEY(s_key), .C1_INIT(s_init), .C1_STB(s_stb), .C1_OUT(C1_OUT)
  );

  // Stub core: registered bit, set on INIT and toggled on every STB, so priming yields 0.
  assign C1_OUT = tog_mode ? tog : 1'b1;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (C1_INIT) tog <= 1'b1;
    else if (C1_STB) tog <= ~tog;
    if (C1_STB) stb_cnt <= stb_cnt + 1;
    if (C1_INIT) init_cnt <= init_cnt + 1;
    if (C1_INIT && C1_STB) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_key(input logic [47:0] k);
    KEY_IN = k;
    KEY_LOAD = 1'b1;
    tick();
    KEY_LOAD = 1'b0;
    tick();
    tick();
  endtask

  task automatic put_byte(input logic [7:0] d);
    int w = 0;
    while (IN_READY !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL put_ready_timeout: IN_READY got %b required 1", IN_READY);
    end
    IN_VALID = 1'b1;
    IN_DATA = d;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack_out();
    $display("byte: in=%h out=%h par=%b cnt_before=%0d", IN_DATA, OUT_DATA, OUT_PAR, BYTE_CNT);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) tick();
    RESETn = 1'b1;
    tick();
    n_checks++;
    if ({KEYED, BUSY, IN_READY, OUT_VALID, OUT_PAR, C1_INIT, C1_STB} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {KEYED, BUSY, IN_READY, OUT_VALID, OUT_PAR, C1_INIT, C1_STB});
    end
    n_checks++;
    if (OUT_DATA !== 8'h00 || BYTE_CNT !== 16'h0 || C1_KEY !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got data=%h cnt=%h key=%h required all zero", OUT_DATA, BYTE_CNT, C1_KEY);
    end
    IN_VALID = 1'b1;
    IN_DATA = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (IN_READY !== 1'b0 || BUSY !== 1'b0 || C1_STB !== 1'b0) begin
        n_fail++;
        $display("FAIL unkeyed_ignore: got ready=%b busy=%b stb=%b required 0 0 0", IN_READY, BUSY, C1_STB);
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_key_load();
    int s0, i0;
    s0 = stb_cnt;
    i0 = init_cnt;
    KEY_IN = 48'hA0A1A2A3A4A5;
    KEY_LOAD = 1'b1;
    tick();
    KEY_LOAD = 1'b0;
    n_checks++;
    if (C1_INIT !== 1'b1 || C1_STB !== 1'b0 || BUSY !== 1'b1 || KEYED !== 1'b0) begin
      n_fail++;
      $display("FAIL load_t1: got init=%b stb=%b busy=%b keyed=%b required 1 0 1 0", C1_INIT, C1_STB, BUSY, KEYED);
    end
    n_checks++;
    if (C1_KEY !== 48'hA0A1A2A3A4A5) begin
      n_fail++;
      $display("FAIL load_key: got %h required a0a1a2a3a4a5", C1_KEY);
    end
    tick();
    n_checks++;
    if (C1_INIT !== 1'b0 || C1_STB !== 1'b1 || KEYED !== 1'b0) begin
      n_fail++;
      $display("FAIL load_t2: got init=%b stb=%b keyed=%b required 0 1 0", C1_INIT, C1_STB, KEYED);
    end
    tick();
    n_checks++;
    if (KEYED !== 1'b1 || IN_READY !== 1'b1 || BUSY !== 1'b0 || C1_STB !== 1'b0) begin
      n_fail++;
      $display("FAIL load_t3: got keyed=%b ready=%b busy=%b stb=%b required 1 1 0 0", KEYED, IN_READY, BUSY, C1_STB);
    end
    repeat (3) tick();
    n_checks++;
    if (stb_cnt - s0 !== 1 || init_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL load_strobes: got stb=%0d init=%0d required 1 1", stb_cnt - s0, init_cnt - i0);
    end
  endtask

  task automatic test_const_stream();
    int lat, s0;
    tog_mode = 1'b0;
    s0 = stb_cnt;
    put_byte(8'hA5);
    wait_out(lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL const_latency: got %0d required 10", lat);
    end
    n_checks++;
    if (OUT_DATA !== 8'h5A || OUT_PAR !== 1'b0) begin
      n_fail++;
      $display("FAIL const_a5: got %h/%b required 5a/0", OUT_DATA, OUT_PAR);
    end
    ack_out();
    n_checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BYTE_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL const_ack: got valid=%b ready=%b cnt=%0d required 0 1 1", OUT_VALID, IN_READY, BYTE_CNT);
    end
    put_byte(8'h01);
    wait_out(lat);
    n_checks++;
    if (OUT_DATA !== 8'hFE || OUT_PAR !== 1'b1) begin
      n_fail++;
      $display("FAIL const_01: got %h/%b required fe/1", OUT_DATA, OUT_PAR);
    end
    ack_out();
    n_checks++;
    if (BYTE_CNT !== 16'd2 || stb_cnt - s0 !== 16) begin
      n_fail++;
      $display("FAIL const_count: got cnt=%0d stb=%0d required 2 16", BYTE_CNT, stb_cnt - s0);
    end
  endtask

  task automatic test_toggle_stream();
    int lat;
    logic [7:0] pt [3];
    logic [7:0] ct [3];
    logic       pr [3];
    pt = '{8'h00, 8'h00, 8'hFF};
    ct = '{8'hAA, 8'hAA, 8'h55};
    pr = '{1'b1, 1'b1, 1'b1};
    tog_mode = 1'b1;
    load_key(48'h123456789ABC);
    for (int i = 0; i < 3; i++) begin
      put_byte(pt[i]);
      wait_out(lat);
      n_checks++;
      if (OUT_DATA !== ct[i] || OUT_PAR !== pr[i] || lat !== 10) begin
        n_fail++;
        $display("FAIL toggle_byte%0d: got %h/%b lat %0d required %h/%b lat 10", i, OUT_DATA, OUT_PAR, lat, ct[i], pr[i]);
      end
      ack_out();
    end
    tog_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [15:0] c0;
    c0 = BYTE_CNT;
    put_byte(8'h3C);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hC3 || OUT_PAR !== 1'b0 || IN_READY !== 1'b0 || C1_STB !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h p=%b r=%b stb=%b required 1 c3 0 0 0",
                 i, OUT_VALID, OUT_DATA, OUT_PAR, IN_READY, C1_STB);
      end
    end
    ack_out();
    n_checks++;
    if (BYTE_CNT !== c0 + 16'd1 || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got cnt=%0d valid=%b required %0d 0", BYTE_CNT, OUT_VALID, c0 + 16'd1);
    end
  endtask

  task automatic test_abort();
    int lat;
    for (int sc = 0; sc < 2; sc++) begin
      if (sc == 0) begin
        put_byte(8'h55);
        repeat (4) tick();
        n_checks++;
        if (C1_STB !== 1'b1 || BUSY !== 1'b1) begin
          n_fail++;
          $display("FAIL abort_in_shift: got stb=%b busy=%b required 1 1", C1_STB, BUSY);
        end
        KEY_IN = 48'h0F0E0D0C0B0A;
        KEY_LOAD = 1'b1;
        tick();
        KEY_LOAD = 1'b0;
      end else begin
        put_byte(8'h11);
        wait_out(lat);
        KEY_IN = 48'hFFEEDDCCBBAA;
        KEY_LOAD = 1'b1;
        OUT_READY = 1'b1;
        tick();
        KEY_LOAD = 1'b0;
        OUT_READY = 1'b0;
      end
      n_checks++;
      if (OUT_VALID !== 1'b0 || BYTE_CNT !== 16'd0 || C1_INIT !== 1'b1 || C1_STB !== 1'b0 || IN_READY !== 1'b0 || KEYED !== 1'b0) begin
        n_fail++;
        $display("FAIL abort%0d_t1: got v=%b cnt=%0d init=%b stb=%b r=%b k=%b required 0 0 1 0 0 0",
                 sc, OUT_VALID, BYTE_CNT, C1_INIT, C1_STB, IN_READY, KEYED);
      end
      n_checks++;
      if (C1_KEY !== ((sc == 0) ? 48'h0F0E0D0C0B0A : 48'hFFEEDDCCBBAA)) begin
        n_fail++;
        $display("FAIL abort%0d_key: got %h", sc, C1_KEY);
      end
      tick();
      n_checks++;
      if (C1_STB !== 1'b1 || C1_INIT !== 1'b0) begin
        n_fail++;
        $display("FAIL abort%0d_t2: got stb=%b init=%b required 1 0", sc, C1_STB, C1_INIT);
      end
      tick();
      n_checks++;
      if (KEYED !== 1'b1 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || BYTE_CNT !== 16'd0) begin
        n_fail++;
        $display("FAIL abort%0d_t3: got k=%b r=%b v=%b cnt=%0d required 1 1 0 0", sc, KEYED, IN_READY, OUT_VALID, BYTE_CNT);
      end
    end
  endtask

  task automatic test_no_parity();
    int lat;
    PARITY_EN = 1'b0;
    put_byte(8'hA5);
    wait_out(lat);
    n_checks++;
    if (lat !== 9 || OUT_DATA !== 8'h5A || OUT_PAR !== 1'b0) begin
      n_fail++;
      $display("FAIL nopar_a5: got lat %0d %h/%b required lat 9 5a/0", lat, OUT_DATA, OUT_PAR);
    end
    ack_out();
    put_byte(8'h01);
    wait_out(lat);
    n_checks++;
    if (lat !== 9 || OUT_DATA !== 8'hFE || OUT_PAR !== 1'b0) begin
      n_fail++;
      $display("FAIL nopar_01: got lat %0d %h/%b required lat 9 fe/0", lat, OUT_DATA, OUT_PAR);
    end
    ack_out();
    PARITY_EN = 1'b1;
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2, w;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 8'h5A;
    c0 = cyc;
    w = 0;
    tick();
    while (IN_READY !== 1'b1 && w < 30) begin tick(); w++; end
    c1 = cyc;
    PARITY_EN = 1'b0;
    w = 0;
    tick();
    while (IN_READY !== 1'b1 && w < 30) begin tick(); w++; end
    c2 = cyc;
    IN_VALID = 1'b0;
    n_checks++;
    if (c1 - c0 !== 11) begin
      n_fail++;
      $display("FAIL b2b_parity: got period %0d required 11", c1 - c0);
    end
    n_checks++;
    if (c2 - c1 !== 10) begin
      n_fail++;
      $display("FAIL b2b_noparity: got period %0d required 10", c2 - c1);
    end
    tick();
    OUT_READY = 1'b0;
    PARITY_EN = 1'b1;
  endtask

  task automatic test_saturation();
    int lat;
    PARITY_EN = 1'b0;
    load_key(48'h555555555555);
    for (int i = 0; i < 17; i++) begin
      put_byte(8'(i * 13));
      wait_out(lat);
      n_checks++;
      if (OUT_DATA !== ~8'(i * 13)) begin
        n_fail++;
        $display("FAIL sat_data%0d: got %h required %h", i, OUT_DATA, ~8'(i * 13));
      end
      ack_out();
    end
    n_checks++;
    if (BYTE_CNT !== 16'd17 || s_byte_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL saturation: got cnt=%0d small=%h required 17 f", BYTE_CNT, s_byte_cnt);
    end
    PARITY_EN = 1'b1;
    n_checks++;
    if (overlap_cnt !== 0) begin
      n_fail++;
      $display("FAIL init_stb_overlap: got %0d cycles required 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_const_stream();
    test_toggle_stream();
    test_backpressure();
    test_abort();
    test_no_parity();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
